// File: rtl/mem_stage_cache_2way.sv
// mem_stage_cache_2way
// Memory-stage data cache between the pipeline MEM stage and a 64-bit SRAM
// controller. It is 2-way set-associative, write-through and
// no-write-allocate, with one 64-bit line (two 32-bit words) per way.
// It also provides an invalidate-all flush, read hit/miss counters and a
// bypass mode (CACHE_EN = 0).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mem_r_en, mem_w_en  load / store request (store wins if both are set)
//   address             byte address; BASE_ADDR is removed before decoding
//   write_data          store data
//   flush               invalidate all lines (deferred while busy)
//   ready               0 = freeze pipeline, 1 = request done or no request
//   read_data           load result, valid when ready && mem_r_en
//   sram_*              SRAM controller handshake (address is unmodified)
//   hit_count           saturating read-hit counter
//   miss_count          saturating read-miss counter
module mem_stage_cache_2way #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SETS      = 64,
    parameter bit          CACHE_EN  = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic             flush,
    output logic             ready,
    output logic [31:0]      read_data,
    output logic             sram_r_en,
    output logic             sram_w_en,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_write_data,
    input  logic [63:0]      sram_read_data,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 3 - IDX_W;

    typedef enum logic [1:0] {IDLE, READ_MISS, WRITE, FLUSH} state_t;

    state_t state, state_nx;

    // address decomposition
    logic [31:0]      a;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_byte_bits;

    assign a                = address - 32'(BASE_ADDR);
    assign word_sel         = a[2];
    assign idx              = a[3 +: IDX_W];
    assign tag              = a[31 -: TAG_W];
    assign unused_byte_bits = ^a[1:0];

    // storage
    logic [1:0]       valid    [SETS];
    logic [TAG_W-1:0] tag_arr  [SETS][2];
    logic [63:0]      data_arr [SETS][2];
    logic [SETS-1:0]  lru;

    // store bookkeeping captured when the store leaves IDLE
    logic wr_hit_q, wr_way_q;
    logic flush_pend;

    // lookup
    logic        hit0, hit1, hit_any, hit_way, victim;
    logic [63:0] hit_line;

    assign hit0     = valid[idx][0] && (tag_arr[idx][0] == tag);
    assign hit1     = valid[idx][1] && (tag_arr[idx][1] == tag);
    assign hit_any  = CACHE_EN && (hit0 || hit1);
    assign hit_way  = hit0 ? 1'b0 : 1'b1;
    assign hit_line = data_arr[idx][hit_way];

    // fill victim: first invalid way (way0 first), otherwise the LRU way
    always_comb begin
        victim = lru[idx];
        if (!valid[idx][0])
            victim = 1'b0;
        else if (!valid[idx][1])
            victim = 1'b1;
    end

    assign sram_address    = address;
    assign sram_write_data = write_data;

    logic req;
    logic do_hit, do_fill, do_wupd, do_flush;

    assign req = mem_r_en || mem_w_en;

    always_comb begin
        state_nx  = state;
        ready     = 1'b1;
        read_data = 32'h0;
        sram_r_en = 1'b0;
        sram_w_en = 1'b0;
        do_hit    = 1'b0;
        do_fill   = 1'b0;
        do_wupd   = 1'b0;
        do_flush  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_w_en) begin
                    ready    = 1'b0;
                    state_nx = WRITE;
                end else if (mem_r_en) begin
                    if (hit_any) begin
                        read_data = word_sel ? hit_line[63:32] : hit_line[31:0];
                        do_hit    = 1'b1;
                    end else begin
                        ready    = 1'b0;
                        state_nx = READ_MISS;
                    end
                end else if (flush || flush_pend) begin
                    state_nx = FLUSH;
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready     = 1'b1;
                    read_data = word_sel ? sram_read_data[63:32] : sram_read_data[31:0];
                    do_fill   = 1'b1;
                    state_nx  = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready    = 1'b1;
                    do_wupd  = wr_hit_q;
                    state_nx = IDLE;
                end
            end
            FLUSH: begin
                // a request arriving here is held and serviced from IDLE
                ready    = !req;
                do_flush = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lru        <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            flush_pend <= 1'b0;
            wr_hit_q   <= 1'b0;
            wr_way_q   <= 1'b0;
            for (int s = 0; s < SETS; s++)
                valid[s] <= 2'b00;
        end else begin
            state <= state_nx;

            if (state == IDLE && mem_w_en) begin
                wr_hit_q <= hit_any;
                wr_way_q <= hit_way;
            end

            // a flush seen while busy waits for the next idle, request-free cycle
            if (state == FLUSH)
                flush_pend <= 1'b0;
            else if (flush && (state != IDLE || req))
                flush_pend <= 1'b1;

            if (do_hit) begin
                lru[idx] <= ~hit_way;
                if (hit_count != '1)
                    hit_count <= hit_count + 1'b1;
            end

            if (do_fill) begin
                if (miss_count != '1)
                    miss_count <= miss_count + 1'b1;
                if (CACHE_EN) begin
                    valid[idx][victim] <= 1'b1;
                    lru[idx]           <= ~victim;
                end
            end

            if (do_wupd)
                lru[idx] <= ~wr_way_q;

            if (do_flush)
                for (int s = 0; s < SETS; s++)
                    valid[s] <= 2'b00;
        end
    end

    // tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (!rst && do_fill && CACHE_EN) begin
            tag_arr[idx][victim]  <= tag;
            data_arr[idx][victim] <= sram_read_data;
        end
        if (!rst && do_wupd) begin
            if (word_sel)
                data_arr[idx][wr_way_q][63:32] <= write_data;
            else
                data_arr[idx][wr_way_q][31:0]  <= write_data;
        end
    end

endmodule

// File: tb/tb_mem_stage_cache_2way.sv
module tb_mem_stage_cache_2way;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // cached instance
    logic        rst, mem_r_en, mem_w_en, flush, ready, sram_r_en, sram_w_en, sram_ready;
    logic [31:0] address, write_data, read_data, sram_address, sram_write_data;
    logic [63:0] sram_read_data;
    logic [15:0] hit_count, miss_count;
    int          cnt;

    // bypass instance
    logic        b_rst, b_mem_r_en, b_mem_w_en, b_flush, b_ready, b_sram_r_en, b_sram_w_en, b_sram_ready;
    logic [31:0] b_address, b_write_data, b_read_data, b_sram_address, b_sram_write_data;
    logic [63:0] b_sram_read_data;
    logic [15:0] b_hit_count, b_miss_count;
    int          b_cnt;

    int n_chk = 0;
    int n_fail = 0;

    mem_stage_cache_2way #(.BASE_ADDR(1024), .SETS(64), .CACHE_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .flush(flush), .ready(ready),
        .read_data(read_data), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    mem_stage_cache_2way #(.BASE_ADDR(1024), .SETS(64), .CACHE_EN(1'b0), .CNT_W(16)) dut_byp (
        .clk(clk), .rst(b_rst), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
        .address(b_address), .write_data(b_write_data), .flush(b_flush), .ready(b_ready),
        .read_data(b_read_data), .sram_r_en(b_sram_r_en), .sram_w_en(b_sram_w_en),
        .sram_address(b_sram_address), .sram_write_data(b_sram_write_data),
        .sram_read_data(b_sram_read_data), .sram_ready(b_sram_ready),
        .hit_count(b_hit_count), .miss_count(b_miss_count)
    );

    // SRAM models: completion pulse in the 5th cycle an enable is held
    always @(posedge clk) begin
        if (rst || !(sram_r_en || sram_w_en) || sram_ready) begin
            sram_ready <= 1'b0;
            cnt        <= 0;
        end else if (cnt == LAT - 1) begin
            sram_ready <= 1'b1;
            cnt        <= 0;
        end else begin
            cnt <= cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (b_rst || !(b_sram_r_en || b_sram_w_en) || b_sram_ready) begin
            b_sram_ready <= 1'b0;
            b_cnt        <= 0;
        end else if (b_cnt == LAT - 1) begin
            b_sram_ready <= 1'b1;
            b_cnt        <= 0;
        end else begin
            b_cnt <= b_cnt + 1;
        end
    end

    // One access on either instance; returns read data, stall cycles, and
    // whether each SRAM enable was seen. Called and returns at posedge+1.
    task automatic access(input bit byp, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output int stall, output bit saw_r, output bit saw_w);
        bit done = 1'b0;
        rd = 32'h0; stall = 0; saw_r = 1'b0; saw_w = 1'b0;
        if (byp) begin
            b_mem_r_en = !wr; b_mem_w_en = wr; b_address = addr; b_write_data = wd;
        end else begin
            mem_r_en = !wr; mem_w_en = wr; address = addr; write_data = wd;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (byp ? b_sram_r_en : sram_r_en) saw_r = 1'b1;
            if (byp ? b_sram_w_en : sram_w_en) saw_w = 1'b1;
            if (byp ? b_ready : ready) begin
                rd   = byp ? b_read_data : read_data;
                done = 1'b1;
            end else begin
                stall++;
            end
            @(posedge clk); #1;
        end
        if (byp) begin b_mem_r_en = 1'b0; b_mem_w_en = 1'b0; end
        else begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_chk++; if ({sram_r_en, sram_w_en} !== 2'b00) begin n_fail++; $display("FAIL reset_sram_en got %b want 00", {sram_r_en, sram_w_en}); end
        n_chk++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset_read_data got %h want 0", read_data); end
        n_chk++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", hit_count, miss_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int st; bit sr, sw;
        sram_read_data = 64'h11111111_22222222;
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5) begin n_fail++; $display("FAIL cold_stall got %0d want 5", st); end
        n_chk++; if (rd !== 32'h22222222) begin n_fail++; $display("FAIL cold_data got %h want 22222222", rd); end
        n_chk++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL cold_miss_count got %0d want 1", miss_count); end
    endtask

    task automatic test_hit();
        logic [31:0] rd; int st; bit sr, sw;
        sram_read_data = 64'hFFFFFFFF_FFFFFFFF;
        access(0, 0, 32'd1028, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 0 || sr) begin n_fail++; $display("FAIL hit_stall got %0d sram_r %b want 0 0", st, sr); end
        n_chk++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL hit_data got %h want 11111111", rd); end
        n_chk++; if (hit_count !== 16'd1) begin n_fail++; $display("FAIL hit_count got %0d want 1", hit_count); end
    endtask

    task automatic test_write();
        logic [31:0] rd; int st; bit sr, sw;
        access(0, 1, 32'd1024, 32'hDEADBEEF, rd, st, sr, sw);
        n_chk++; if (st != 5 || !sw || sr) begin n_fail++; $display("FAIL wr_hit_sram got stall %0d w %b r %b want 5 1 0", st, sw, sr); end
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_hit_coherent got %h stall %0d want deadbeef 0", rd, st); end
        // store miss must not allocate
        access(0, 1, 32'd1032, 32'h01234567, rd, st, sr, sw);
        n_chk++; if (st != 5 || !sw) begin n_fail++; $display("FAIL wr_miss_sram got stall %0d w %b want 5 1", st, sw); end
        sram_read_data = 64'hAAAA0000_BBBB1111;
        access(0, 0, 32'd1032, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'hBBBB1111) begin n_fail++; $display("FAIL wr_miss_no_alloc got %h stall %0d want bbbb1111 5", rd, st); end
        n_chk++; if (hit_count !== 16'd2 || miss_count !== 16'd2) begin n_fail++; $display("FAIL wr_counts got %0d/%0d want 2/2", hit_count, miss_count); end
    endtask

    task automatic test_lru();
        logic [31:0] rd; int st; bit sr, sw;
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 0) begin n_fail++; $display("FAIL lru_a_hit got stall %0d want 0", st); end
        sram_read_data = 64'h33333333_44444444;
        access(0, 0, 32'd1536, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'h44444444) begin n_fail++; $display("FAIL lru_b_fill got %h stall %0d want 44444444 5", rd, st); end
        sram_read_data = 64'h55555555_66666666;
        access(0, 0, 32'd2048, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'h66666666) begin n_fail++; $display("FAIL lru_c_fill got %h stall %0d want 66666666 5", rd, st); end
        sram_read_data = 64'h0;
        access(0, 0, 32'd1536, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 0 || rd !== 32'h44444444) begin n_fail++; $display("FAIL lru_b_kept got %h stall %0d want 44444444 0", rd, st); end
        sram_read_data = 64'h77777777_88888888;
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'h88888888) begin n_fail++; $display("FAIL lru_a_evicted got %h stall %0d want 88888888 5", rd, st); end
        n_chk++; if (hit_count !== 16'd4 || miss_count !== 16'd5) begin n_fail++; $display("FAIL lru_counts got %0d/%0d want 4/5", hit_count, miss_count); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; int st; bit sr, sw; bit done;
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 0 || rd !== 32'h88888888) begin n_fail++; $display("FAIL flush_pre_hit got %h stall %0d want 88888888 0", rd, st); end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", ready); end
        @(posedge clk); #1;
        sram_read_data = 64'h99999999_12345678;
        access(0, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'h12345678) begin n_fail++; $display("FAIL flush_miss got %h stall %0d want 12345678 5", rd, st); end
        // flush raised during a pending miss is deferred until it completes
        sram_read_data = 64'h0BADF00D_CAFEF00D;
        mem_r_en = 1'b1; address = 32'd2048;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        done = 1'b0; rd = 32'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) begin rd = read_data; done = 1'b1; end
            @(posedge clk); #1;
        end
        mem_r_en = 1'b0;
        n_chk++; if (!done || rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL flush_pend_miss got %h done %b want cafef00d 1", rd, done); end
        repeat (2) @(posedge clk); #1;
        sram_read_data = 64'hFEEDFACE_13572468;
        access(0, 0, 32'd2048, 32'h0, rd, st, sr, sw);
        n_chk++; if (st != 5 || rd !== 32'h13572468) begin n_fail++; $display("FAIL flush_deferred got %h stall %0d want 13572468 5", rd, st); end
        n_chk++; if (hit_count !== 16'd5 || miss_count !== 16'd8) begin n_fail++; $display("FAIL flush_counts got %0d/%0d want 5/8", hit_count, miss_count); end
    endtask

    task automatic test_bypass_reset();
        logic [31:0] rd; int st; bit sr, sw;
        b_sram_read_data = 64'h11111111_22222222;
        access(1, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (!sr || st != 5 || rd !== 32'h22222222) begin n_fail++; $display("FAIL byp_read1 got %h stall %0d r %b want 22222222 5 1", rd, st, sr); end
        access(1, 0, 32'd1024, 32'h0, rd, st, sr, sw);
        n_chk++; if (!sr || st != 5 || rd !== 32'h22222222) begin n_fail++; $display("FAIL byp_read2 got %h stall %0d r %b want 22222222 5 1", rd, st, sr); end
        access(1, 1, 32'd1024, 32'h5A5A5A5A, rd, st, sr, sw);
        n_chk++; if (!sw || sr || st != 5) begin n_fail++; $display("FAIL byp_write got w %b r %b stall %0d want 1 0 5", sw, sr, st); end
        n_chk++; if (b_hit_count !== 16'd0 || b_miss_count !== 16'd2) begin n_fail++; $display("FAIL byp_counts got %0d/%0d want 0/2", b_hit_count, b_miss_count); end
        b_mem_r_en = 1'b1; b_address = 32'd1024;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (b_sram_r_en !== 1'b1) begin n_fail++; $display("FAIL byp_pending got sram_r_en %b want 1", b_sram_r_en); end
        @(posedge clk); #1 b_rst = 1'b1; b_mem_r_en = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({b_sram_r_en, b_sram_w_en} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_en got %b want 00", {b_sram_r_en, b_sram_w_en}); end
        n_chk++; if (b_hit_count !== 16'd0 || b_miss_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_counts got %0d/%0d want 0/0", b_hit_count, b_miss_count); end
        b_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'h0; write_data = 32'h0;
        flush = 1'b0; sram_read_data = 64'h0;
        b_rst = 1'b1; b_mem_r_en = 1'b0; b_mem_w_en = 1'b0; b_address = 32'h0; b_write_data = 32'h0;
        b_flush = 1'b0; b_sram_read_data = 64'h0;
        test_reset();
        test_cold_read();
        test_hit();
        test_write();
        test_lru();
        test_flush();
        test_bypass_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // SRAM enables must never overlap
    always @(negedge clk) begin
        if (!rst && sram_r_en && sram_w_en) begin
            n_chk++; n_fail++;
            $display("FAIL sram_en_overlap got r=1 w=1 want not both");
        end
    end

endmodule

// File: doc/mem_stage_cache_2way.md
Name: mem_stage_cache_2way

Overview:
Parametrised memory-stage data cache that sits between the pipeline's MEM stage and the 64-bit SRAM controller.
- 2-way set-associative, write-through, no-write-allocate. One line is 64 bits (two 32-bit words), matching the SRAM word.
- Integrates tag/valid/LRU/data arrays and the miss/write FSM. Exposes `ready` as the pipeline freeze signal.
- Adds an invalidate-all flush, hit/miss counters and a cache-bypass mode.

Parameters:
- `BASE_ADDR`, 1024: byte offset subtracted from `address` before decomposition.
- `SETS`, 64: number of sets. Power of two, at least 2. `IDX_W` = log2(`SETS`).
- `CACHE_EN`, 1: 1 = cache active; 0 = bypass, every access goes to SRAM.
- `CNT_W`, 16: width of the hit/miss counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_r_en`  in  1  load request from the MEM stage.
- `mem_w_en`  in  1  store request from the MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Val_Rm).
- `flush`  in  1  invalidate all lines.
- `ready`  out  1  0 = freeze pipeline; 1 = current request complete, or no request.
- `read_data`  out  32  load result, valid when `ready`=1 and `mem_r_en`=1.
- `sram_r_en`  out  1  SRAM read request.
- `sram_w_en`  out  1  SRAM write request.
- `sram_address`  out  32  address to the SRAM controller (unmodified `address`).
- `sram_write_data`  out  32  store data to SRAM.
- `sram_read_data`  in  64  line returned by SRAM.
- `sram_ready`  in  1  SRAM controller completion pulse.
- `hit_count`  out  `CNT_W`  read-hit counter.
- `miss_count`  out  `CNT_W`  read-miss counter.

Behaviour:
- Address mapping: a = `address` − `BASE_ADDR`.
  - Word select = a[2].
  - Index = a[3+IDX_W-1:3].
  - Tag = a[31:3+IDX_W].
- Per set: valid[2], tag[2], data[2] (64-bit each), one LRU bit naming the least-recently-used way.
- Reset: all valid bits 0, LRU 0, state IDLE.
  - `sram_r_en`=0, `sram_w_en`=0.
  - Counters 0.
  - `read_data`=0.
  - `ready`=1 when no request is present.
- FSM states: IDLE, READ_MISS, WRITE, FLUSH.
- IDLE:
  - No request: `ready`=1.
  - `mem_w_en`=1 (wins if both enables are set): `ready`=0. Latch hit/way, go to WRITE.
  - `mem_r_en`=1 and hit (valid && tag match in either way):
    - `ready`=1 combinationally in the same cycle; `read_data` = selected word of the hit way.
    - At the clock edge: LRU ← other way; `hit_count`+1.
  - `mem_r_en`=1 and miss: `ready`=0, go to READ_MISS.
  - `flush`=1 with no request: go to FLUSH.
  - `flush` asserted while not in IDLE: latched and serviced on the next IDLE cycle that has no request.
- READ_MISS:
  - Holds `sram_r_en`=1 until `sram_ready`=1.
  - In the `sram_ready` cycle:
    - Victim = first invalid way (way0 preferred), else the LRU way.
    - Write line, tag and valid to the victim.
    - LRU ← non-victim.
    - `read_data` = `sram_read_data` word selected by a[2].
    - `ready`=1, `miss_count`+1, return to IDLE.
  - Miss latency = SRAM latency + 1 cycle.
- WRITE:
  - Holds `sram_w_en`=1 until `sram_ready`=1.
  - On `sram_ready`: if the latched access was a hit, update the selected 32-bit word in the hit way; LRU ← other way.
  - Then `ready`=1 and return to IDLE. A miss leaves the cache unchanged.
- FLUSH: clears all valid bits in one cycle, then returns to IDLE. `ready`=1 throughout, because no memory request is present.
- `sram_r_en` and `sram_w_en` are never asserted together, and both are 0 in IDLE.
- Counters saturate at all-ones.
- `CACHE_EN`=0:
  - Reads behave as misses that do not fill the cache; writes go straight to SRAM.
  - `hit_count` stays 0; `miss_count` counts reads.
- Reset mid-transaction: the pending access is dropped and the SRAM enables deassert at the reset edge. The pipeline re-issues the access.
- Request signals must stay stable while `ready`=0. Violating this is undefined.

Test Plan:
1. Cold read: reset, read address 1024; SRAM returns `64'h11111111_22222222` after 4 cycles.
   - Required: `ready`=0 for 5 cycles, then `read_data`=`32'h22222222`.
   - Required: `miss_count`=1.
2. Re-read hit: immediately read address 1028.
   - Required: `ready`=1 in the same cycle, `read_data`=`32'h11111111`, no `sram_r_en`.
   - Required: `hit_count`=1.
3. Write-hit coherence: write `32'hDEADBEEF` to 1024, then read 1024.
   - Required: `sram_w_en` pulses until `sram_ready`.
   - Required: the read hits and returns `32'hDEADBEEF`.
4. LRU eviction (`SETS`=64): read 1024, then 1024+512, then 1024+1024 (all set 0).
   - Required: the third access evicts the 1024 line.
   - Required: a re-read of 1024+512 hits; a re-read of 1024 misses.
5. Flush: after scenario 2, assert `flush` for 1 cycle, then read 1024.
   - Required: the read misses.
   - Required: a `flush` asserted during a pending READ_MISS is applied after that miss completes.
6. Bypass and reset: with `CACHE_EN`=0, two reads of 1024 each assert `sram_r_en`, and `hit_count` stays 0. Assert `rst` mid-READ_MISS.
   - Required: `sram_r_en`=0 and both counters 0 after the reset edge.
